// File: rtl/cifra_cesar_stream.sv
// Streaming Caesar-cipher engine: valid/ready symbol input, run-time key with
// encrypt/decrypt modular shift, and a small output FIFO with back-pressure.
module cifra_cesar_stream #(
  parameter int SYM_W = 5,
  parameter int ALPHA = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [SYM_W-1:0] key_in,
  output logic             key_err,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_err,
  output logic [1:0]       key_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SYM_W:0]   ALPHA_X = (SYM_W + 1)'(ALPHA);
  localparam logic [CNT_W-1:0] DEPTH_X = CNT_W'(DEPTH);

  localparam logic [1:0] ST_NOKEY = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0]       state_reg;
  logic [SYM_W-1:0] key_reg;
  logic [SYM_W-1:0] pend_reg;
  logic             key_err_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [SYM_W-1:0] ent_sym_reg [DEPTH];
  logic             ent_err_reg [DEPTH];

  logic             key_legal;
  logic             sym_legal;
  logic             push;
  logic             pop;
  logic [SYM_W:0]   sum_w;
  logic [SYM_W:0]   dif_w;
  logic [SYM_W:0]   shift_w;
  logic [SYM_W-1:0] res_sym;

  assign key_legal = ({1'b0, key_in} < ALPHA_X);
  assign sym_legal = ({1'b0, in_sym} < ALPHA_X);

  assign in_ready  = (state_reg == ST_RUN) && !key_load && (count_reg < DEPTH_X);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_sym   = ent_sym_reg[rd_ptr_reg];
  assign out_err   = ent_err_reg[rd_ptr_reg];
  assign key_err   = key_err_reg;
  assign key_state = state_reg;

  // One extra bit keeps the encrypt carry and the decrypt borrow visible.
  always_comb begin
    sum_w   = {1'b0, in_sym} + {1'b0, key_reg};
    dif_w   = {1'b0, in_sym} - {1'b0, key_reg};
    shift_w = sum_w;
    if (mode) begin
      shift_w = dif_w;
      if (dif_w[SYM_W]) shift_w = dif_w + ALPHA_X;
    end else if (sum_w >= ALPHA_X) begin
      shift_w = sum_w - ALPHA_X;
    end
    res_sym = sym_legal ? SYM_W'(shift_w) : in_sym;
  end

  // Key/state machine; illegal keys leave key, pending key and state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_NOKEY;
      key_reg     <= '0;
      pend_reg    <= '0;
      key_err_reg <= 1'b0;
    end else begin
      key_err_reg <= key_load && !key_legal;
      case (state_reg)
        ST_NOKEY: begin
          if (key_load && key_legal) begin
            key_reg   <= key_in;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (key_load && key_legal) begin
            if (count_reg == '0) begin
              key_reg <= key_in;
            end else begin
              pend_reg  <= key_in;
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (key_load && key_legal) pend_reg <= key_in;
          if (count_reg == '0) begin
            // A key arriving on the exit edge is the newest, so it wins.
            key_reg   <= (key_load && key_legal) ? key_in : pend_reg;
            state_reg <= ST_RUN;
          end
        end
        default: state_reg <= ST_NOKEY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_sym_reg[i] <= '0;
        ent_err_reg[i] <= 1'b0;
      end
    end else if (push) begin
      ent_sym_reg[wr_ptr_reg] <= res_sym;
      ent_err_reg[wr_ptr_reg] <= !sym_legal;
    end
  end

endmodule

// File: doc/cifra_cesar_stream.md
# cifra_cesar_stream

Streaming, parametrised Caesar-cipher engine and successor to the fixed 4-bit combinational encoder. It accepts one symbol per clock over a valid/ready handshake and applies a run-time loadable shift key in encrypt or decrypt mode, with modular wrap over a configurable alphabet. Results are buffered in a small output FIFO with downstream back-pressure. Key changes are serialised against in-flight data by a drain state machine. The block sits between the symbol source (keyboard/UART decoder) and the display/transmit stage.

## Interface
- SYM_W, 5, symbol and key width in bits
- ALPHA, 26, alphabet size; legal symbols 0..ALPHA-1; constraint 2 ≤ ALPHA ≤ 2^SYM_W
- DEPTH, 4, output FIFO entries (power of two, ≥ 2)
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- key_load  in  1  one-cycle request to load key_in
- key_in  in  SYM_W  new shift key
- key_err  out  1  registered one-cycle pulse: rejected key (key_in ≥ ALPHA)
- mode  in  1  0 = encrypt (+key), 1 = decrypt (−key); sampled per accepted symbol
- in_valid  in  1  in_sym valid
- in_ready  out  1  block can accept this cycle
- in_sym  in  SYM_W  plaintext/ciphertext symbol
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_sym  out  SYM_W  result symbol (FIFO head)
- out_err  out  1  head came from an illegal input symbol
- key_state  out  2  00 NOKEY, 01 RUN, 10 DRAIN

## Operation
- States:
  - NOKEY: no key loaded; in_ready = 0. A valid key_load writes the key and moves to RUN.
  - RUN: normal streaming.
  - DRAIN: a key change is waiting for buffered data to leave.
- key_load with key_in ≥ ALPHA, in any state: key_err pulses the next cycle; key, pending key and state are unchanged.
- Valid key_load in RUN:
  - FIFO count = 0: key is updated at that edge; state stays RUN.
  - FIFO count > 0: key_in is latched as the pending key; state moves to DRAIN.
- DRAIN: in_ready = 0. Another valid key_load overwrites the pending key (last one wins). When count = 0, the pending key is moved to the key and the state returns to RUN on the same edge.
- in_ready = (state == RUN) & ~key_load & (count < DEPTH). There is no pass-through when the FIFO is full.
- Accept happens when in_valid & in_ready. The result is computed combinationally and written to the FIFO at that edge.
- Arithmetic is done in SYM_W+1 bits:
  - Encrypt: t = in_sym + key; if t ≥ ALPHA then t − ALPHA.
  - Decrypt: t = in_sym − key; if negative then + ALPHA.
  - The result is always in 0..ALPHA-1.
- Illegal input (in_sym ≥ ALPHA): the entry is written with out_sym = in_sym unchanged and out_err = 1. It is never shifted.
- Pop happens when out_valid & out_ready. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- out_valid = (count ≠ 0). out_sym and out_err are the FIFO head and are held stable while out_valid & ~out_ready.

## Timing
- Reset values: state NOKEY, key 0, pending key 0, count 0, pointers 0. Outputs: in_ready 0, out_valid 0, out_sym 0, out_err 0, key_err 0, key_state 00.
- Latency from accept edge to out_valid high is 1 cycle when the FIFO was empty.
- Throughput is 1 symbol per cycle while out_ready stays high.
- A key loaded at edge N applies to symbols accepted at edge N+1 onward, first possible after the state update.
- DRAIN exit: the pending key becomes active on the edge on which count is 0. in_ready can rise in the following cycle.
- Reset asserted mid-stream or mid-DRAIN: the FIFO contents and pending key are discarded immediately. Outputs take their reset values asynchronously.
- key_load and in_valid in the same RUN cycle: key_load wins, and in_ready is 0 that cycle.

## Test plan
- Reset and lock: after reset, drive in_valid = 1 with no key -> in_ready = 0, out_valid = 0, key_state = 00 throughout.
- Encrypt wrap (key 3, mode 0): stream 0, 22, 25 -> out_sym 3, 25, 2 with out_err = 0; out_valid rises 1 cycle after the first accept.
- Decrypt wrap (key 3, mode 1): input 1 -> 24; input 3 -> 0. Toggling mode between consecutive symbols applies per symbol.
- Illegal symbol and bad key:
  - in_sym 28 -> out_sym 28, out_err = 1.
  - key_in 26 -> key_err pulses for 1 cycle; old key is still used.
- Back-pressure: hold out_ready = 0 and push 4 symbols -> in_ready = 0 at count 4, head is held stable. Release -> 4 pops in order with no loss or duplicates.
- Key change mid-stream: fill 2 entries, load key 5 -> DRAIN with in_ready = 0. Drain both entries -> RUN; next input 0 -> 5. Then assert reset mid-DRAIN -> immediate reset values on all outputs.
